// File: rtl/max_pool_2x2_stream_pkg.sv
// Shared definitions for the 2x2 streaming pooling block: pooling mode encoding
// and the width helper used to size counters and line-buffer addresses.
package max_pool_2x2_stream_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/max_pool_2x2_stream_if.sv
// Pixel-stream bundle between the upstream activation stage (master) and the
// pooling block (slave); clock and reset travel as plain ports.
interface max_pool_2x2_stream_if #(
  parameter int WL = 8
);

  logic          iCLR;
  logic          iVALID;
  logic [WL-1:0] iDATA;
  logic          iMODE;
  logic          oVALID;
  logic [WL-1:0] oDATA;
  logic          oFRAME_DONE;
  logic          oBUSY;

  modport master (
    output iCLR, iVALID, iDATA, iMODE,
    input  oVALID, oDATA, oFRAME_DONE, oBUSY
  );

  modport slave (
    input  iCLR, iVALID, iDATA, iMODE,
    output oVALID, oDATA, oFRAME_DONE, oBUSY
  );

endinterface

// File: rtl/max_pool_2x2_stream_line_buf.sv
// One-row store of horizontal pair results, written on even rows and read back
// on odd rows at the same column pair; storage is deliberately left unreset.
module max_pool_2x2_stream_line_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 9,
  parameter int AW    = 4
) (
  input  logic          iCLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge iCLK) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-ordered feature map,
// producing one registered sample per window one cycle after its last pixel.
module max_pool_2x2_stream
  import max_pool_2x2_stream_pkg::*;
#(
  parameter int WL    = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int CWB   = clog2(IMG_W),
  parameter int RWB   = clog2(IMG_H)
) (
  input logic                   iCLK,
  input logic                   iRSTn,
  max_pool_2x2_stream_if.slave  bus
);

  localparam int DEPTH = IMG_W / 2;
  localparam int LB_AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [CWB-1:0] r_col;
  logic [RWB-1:0] r_row;
  pool_mode_e     r_mode;
  logic [WL-1:0]  r_hold;
  logic           r_oValid;
  logic [WL-1:0]  r_oData;
  logic           r_oFrameDone;

  logic             w_accept;
  logic             w_colLast;
  logic             w_rowLast;
  logic             w_lbWe;
  logic             w_emit;
  logic [LB_AW-1:0] w_lbAddr;
  logic [WL:0]      w_pair;
  logic [WL:0]      w_lbRd;
  logic [WL+1:0]    w_sum;
  logic [WL-1:0]    w_result;

  assign w_accept  = bus.iVALID & ~bus.iCLR;
  assign w_colLast = (r_col == CWB'(IMG_W - 1));
  assign w_rowLast = (r_row == RWB'(IMG_H - 1));
  assign w_lbWe    = w_accept & r_col[0] & ~r_row[0];
  assign w_emit    = w_accept & r_col[0] & r_row[0];
  assign w_lbAddr  = LB_AW'(r_col >> 1);

  // Horizontal pair: the sum keeps a carry bit so the 2x2 average never wraps.
  always_comb begin
    w_pair = '0;
    if (r_mode == POOL_AVG) begin
      w_pair = {1'b0, r_hold} + {1'b0, bus.iDATA};
    end else begin
      w_pair = {1'b0, (bus.iDATA > r_hold) ? bus.iDATA : r_hold};
    end
  end

  assign w_sum = {1'b0, w_pair} + {1'b0, w_lbRd};

  always_comb begin
    w_result = '0;
    if (r_mode == POOL_AVG) begin
      w_result = WL'(w_sum >> 2);
    end else begin
      w_result = WL'((w_pair > w_lbRd) ? w_pair : w_lbRd);
    end
  end

  max_pool_2x2_stream_line_buf #(
    .DEPTH (DEPTH),
    .DW    (WL + 1),
    .AW    (LB_AW)
  ) u_lineBuf (
    .iCLK    (iCLK),
    .i_we    (w_lbWe),
    .i_addr  (w_lbAddr),
    .i_wdata (w_pair),
    .o_rdata (w_lbRd)
  );

  // Clear behaves like reset; a stalled cycle freezes everything but the output pulse.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_mode       <= POOL_MAX;
      r_hold       <= '0;
      r_oValid     <= 1'b0;
      r_oData      <= '0;
      r_oFrameDone <= 1'b0;
    end else if (bus.iCLR) begin
      r_col        <= '0;
      r_row        <= '0;
      r_mode       <= POOL_MAX;
      r_hold       <= '0;
      r_oValid     <= 1'b0;
      r_oData      <= '0;
      r_oFrameDone <= 1'b0;
    end else begin
      r_oValid     <= w_emit;
      r_oFrameDone <= w_emit & w_colLast & w_rowLast;
      if (w_emit) begin
        r_oData <= w_result;
      end
      if (bus.iVALID) begin
        if ((r_col == '0) && (r_row == '0)) begin
          r_mode <= pool_mode_e'(bus.iMODE);
        end
        if (!r_col[0]) begin
          r_hold <= bus.iDATA;
        end
        if (w_colLast) begin
          r_col <= '0;
          r_row <= w_rowLast ? '0 : r_row + RWB'(1);
        end else begin
          r_col <= r_col + CWB'(1);
        end
      end
    end
  end

  assign bus.oVALID      = r_oValid;
  assign bus.oDATA       = r_oData;
  assign bus.oFRAME_DONE = r_oFrameDone;
  assign bus.oBUSY       = (r_col != '0) || (r_row != '0);

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Self-checking bench for max_pool_2x2_stream on a 4x4 map: a table of whole
// frames plus hand-written stall, clear, reset, mode-flip and back-to-back runs.
module tb_max_pool_2x2_stream;

  logic iCLK  = 1'b0;
  logic iRSTn = 1'b0;

  max_pool_2x2_stream_if #(.WL(8)) bus ();

  max_pool_2x2_stream #(
    .WL    (8),
    .IMG_W (4),
    .IMG_H (4)
  ) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .bus   (bus)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [7:0]  data;
    logic        done;
    logic [31:0] edgeNo;
  } sbEntry_t;

  typedef struct packed {
    logic        mode;
    logic [1:0]  pattern;
    logic [31:0] exp;
  } frameVec_t;

  sbEntry_t  sbQueue[$];
  frameVec_t vecs[6];
  int        checks    = 0;
  int        errors    = 0;
  int        edgeCount = 0;
  int        doneCount = 0;

  always @(posedge iCLK) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic clr, input logic mode);
    @(posedge iCLK);
    #1;
    bus.iVALID = valid;
    bus.iDATA  = data;
    bus.iCLR   = clr;
    bus.iMODE  = mode;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'hA5, 1'b0, bus.iMODE);
  endtask

  function automatic logic [7:0] pixelOf(input logic [1:0] pat, input int idx);
    case (pat)
      2'd0:    return 8'(idx);
      2'd1:    return 8'd255;
      2'd2:    return 8'(15 - idx);
      default: return 8'(idx * 17);
    endcase
  endfunction

  // Drives nPix pixels of a frame; windows complete on pixels 5, 7, 13 and 15.
  task automatic sendFrame(input logic [1:0] pat, input logic mode, input logic [31:0] exp,
                           input int stallPct, input int flipAt, input int nPix);
    logic curMode;
    int   k;
    sbEntry_t e;
    k = 0;
    for (int i = 0; i < nPix; i++) begin
      curMode = (i >= flipAt) ? ~mode : mode;
      for (int s = 0; s < 4 && int'($urandom_range(0, 99)) < stallPct; s++) begin
        applyStimulus(1'b0, 8'($urandom), 1'b0, curMode);
      end
      applyStimulus(1'b1, pixelOf(pat, i), 1'b0, curMode);
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        e.data   = exp[8*k +: 8];
        e.done   = (i == 15);
        e.edgeNo = 32'(edgeCount + 1);
        sbQueue.push_back(e);
        k++;
      end
    end
  endtask

  // Scoreboard monitor: every oVALID must match the oldest expectation on its exact cycle.
  initial begin
    sbEntry_t e;
    forever begin
      @(negedge iCLK);
      if (bus.oFRAME_DONE === 1'b1) doneCount++;
      while (sbQueue.size() > 0 && int'(sbQueue[0].edgeNo) < edgeCount) begin
        e = sbQueue.pop_front();
        checkOutput("missing_output", 32'(bus.oVALID), 32'd1);
      end
      if (bus.oVALID === 1'b1) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_output", 32'(bus.oDATA), 32'hFFFF_FFFF);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("out_cycle", 32'(edgeCount), e.edgeNo);
          checkOutput("out_data", 32'(bus.oDATA), 32'(e.data));
          checkOutput("out_frame_done", 32'(bus.oFRAME_DONE), 32'(e.done));
        end
      end else if (bus.oFRAME_DONE !== 1'b0) begin
        checkOutput("done_without_valid", 32'(bus.oFRAME_DONE), 32'd0);
      end
    end
  end

  initial begin
    int doneBase;

    vecs[0] = '{mode: 1'b0, pattern: 2'd0, exp: {8'd15,  8'd13,  8'd7,   8'd5}};
    vecs[1] = '{mode: 1'b1, pattern: 2'd0, exp: {8'd12,  8'd10,  8'd4,   8'd2}};
    vecs[2] = '{mode: 1'b1, pattern: 2'd1, exp: {8'd255, 8'd255, 8'd255, 8'd255}};
    vecs[3] = '{mode: 1'b0, pattern: 2'd2, exp: {8'd5,   8'd7,   8'd13,  8'd15}};
    vecs[4] = '{mode: 1'b1, pattern: 2'd3, exp: {8'd212, 8'd178, 8'd76,  8'd42}};
    vecs[5] = '{mode: 1'b0, pattern: 2'd3, exp: {8'd255, 8'd221, 8'd119, 8'd85}};

    bus.iVALID = 1'b0;
    bus.iDATA  = 8'd0;
    bus.iCLR   = 1'b0;
    bus.iMODE  = 1'b0;

    repeat (3) @(posedge iCLK);
    #1;
    checkOutput("reset_valid", 32'(bus.oVALID), 32'd0);
    checkOutput("reset_data", 32'(bus.oDATA), 32'd0);
    checkOutput("reset_done", 32'(bus.oFRAME_DONE), 32'd0);
    checkOutput("reset_busy", 32'(bus.oBUSY), 32'd0);
    iRSTn = 1'b1;

    $display("[TB] table of frames");
    for (int v = 0; v < 6; v++) begin
      sendFrame(vecs[v].pattern, vecs[v].mode, vecs[v].exp, 0, 16, 16);
      idle(3);
      checkOutput("busy_after_frame", 32'(bus.oBUSY), 32'd0);
    end

    $display("[TB] random stalls");
    sendFrame(2'd0, 1'b0, vecs[0].exp, 50, 16, 16);
    idle(3);

    $display("[TB] iMODE flip mid-frame, then average frame");
    sendFrame(2'd0, 1'b0, vecs[0].exp, 0, 4, 16);
    sendFrame(2'd0, 1'b1, vecs[1].exp, 0, 16, 16);
    idle(3);

    $display("[TB] clear after pixel 9");
    sendFrame(2'd0, 1'b0, vecs[0].exp, 0, 16, 10);
    applyStimulus(1'b1, 8'd99, 1'b1, 1'b0);
    checkOutput("busy_before_clear", 32'(bus.oBUSY), 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("clear_data", 32'(bus.oDATA), 32'd0);
    checkOutput("clear_busy", 32'(bus.oBUSY), 32'd0);
    idle(2);
    sendFrame(2'd0, 1'b0, vecs[0].exp, 0, 16, 16);
    idle(3);

    $display("[TB] async reset mid-frame");
    sendFrame(2'd0, 1'b0, vecs[0].exp, 0, 16, 10);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("hold_data", 32'(bus.oDATA), 32'd7);
    checkOutput("busy_mid_frame", 32'(bus.oBUSY), 32'd1);
    iRSTn = 1'b0;
    #1;
    checkOutput("rst_mid_data", 32'(bus.oDATA), 32'd0);
    checkOutput("rst_mid_busy", 32'(bus.oBUSY), 32'd0);
    checkOutput("rst_mid_valid", 32'(bus.oVALID), 32'd0);
    idle(2);
    iRSTn = 1'b1;
    sendFrame(2'd0, 1'b0, vecs[0].exp, 0, 16, 16);
    idle(3);

    $display("[TB] back-to-back frames");
    doneBase = doneCount;
    sendFrame(2'd0, 1'b0, vecs[0].exp, 0, 16, 16);
    sendFrame(2'd3, 1'b1, vecs[4].exp, 0, 16, 16);
    idle(3);
    checkOutput("b2b_frame_done_count", 32'(doneCount - doneBase), 32'd2);

    checkOutput("queue_drained", 32'(sbQueue.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
